// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Purpose:
//   Receive half of the board UART. The asynchronous rxd pin is synchronised
//   and oversampled on the system clock. 8N1 frames (LSB first) are assembled
//   and queued in a small show-ahead FIFO that the CPU core drains with an
//   empty / rdreq / q handshake. Bad stop bits and dropped bytes are flagged.
//
// Parameters:
//   CLKS_PER_BIT  system clocks per serial bit (>= 8)
//   DEPTH_LOG2    FIFO depth is 2**DEPTH_LOG2 bytes
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rxd        in   serial line, idle high, asynchronous to clk
//   rdreq      in   pop the head byte this cycle (ignored while empty)
//   q          out  head byte of the FIFO, valid while empty is low
//   empty      out  FIFO holds no bytes
//   full       out  FIFO holds 2**DEPTH_LOG2 bytes
//   frame_err  out  one-cycle pulse when a stop bit is sampled low
//   overrun    out  sticky flag: a received byte was dropped (FIFO full)
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  input  logic       rdreq,
  output logic [7:0] q,
  output logic       empty,
  output logic       full,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int PW    = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Input synchroniser. Two flops bring rxd into the clock domain (rxSync_q
  // is the usable line value); a third copy holds the previous value so a
  // 1->0 transition can be detected. All preset to the idle-high level.
  // -------------------------------------------------------------------------
  logic rxMeta_q;
  logic rxSync_q;
  logic rxPrev_q;
  logic fallEdge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= rxd;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  // A held-low line produces no edge, so a break cannot retrigger a frame.
  assign fallEdge = rxPrev_q & ~rxSync_q;

  // -------------------------------------------------------------------------
  // Framer state registers.
  // -------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bitIdx_q, bitIdx_d;
  logic [7:0]      shift_q, shift_d;
  logic            frameErr_q, frameErr_d;
  logic            push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      frameErr_q <= frameErr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Framer next state. START waits half a bit to land in the middle of the
  // start bit and rejects glitches shorter than that; from there every
  // sample is a full bit period later, i.e. at the centre of each bit.
  // push is asserted in the same cycle the stop bit is sampled high.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    frameErr_d = 1'b0;
    push       = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        bitIdx_d = '0;
        if (fallEdge) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d    = '0;
          bitIdx_d = '0;
          state_d  = rxSync_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d             = '0;
          shift_d[bitIdx_q] = rxSync_q;
          if (bitIdx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rxSync_q) begin
            push = 1'b1;
          end else begin
            frameErr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign frame_err = frameErr_q;

  // -------------------------------------------------------------------------
  // FIFO pointers carry one extra bit so full and empty can be told apart
  // when the lower bits match. Both flags depend only on registered
  // pointers, so there is no combinational path from rdreq.
  // -------------------------------------------------------------------------
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [7:0]    mem_q [DEPTH];
  logic          overrun_q, overrun_d;
  logic          popOk;
  logic          pushOk;

  assign empty = (wrPtr_q == rdPtr_q);
  assign full  = (wrPtr_q[PW-1] != rdPtr_q[PW-1]) &&
                 (wrPtr_q[PW-2:0] == rdPtr_q[PW-2:0]);

  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // still accepted when rdreq is high.
  always_comb begin
    popOk     = rdreq & ~empty;
    pushOk    = push & (~full | popOk);
    wrPtr_d   = wrPtr_q + PW'(pushOk);
    rdPtr_d   = rdPtr_q + PW'(popOk);
    overrun_d = overrun_q | (push & ~pushOk);
  end

  // -------------------------------------------------------------------------
  // FIFO storage and flags. Memory is cleared on reset so q reads zero.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      overrun_q <= overrun_d;
      if (pushOk) begin
        mem_q[wrPtr_q[PW-2:0]] <= shift_q;
      end
    end
  end

  assign q       = mem_q[rdPtr_q[PW-2:0]];
  assign overrun = overrun_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial receive path from the board's rxd pin to the CPU core. Complements the transmit path, which the core drives with wrreq and a data byte.
- Oversamples rxd on the fast system clock and frames 8N1 bytes (LSB first).
- Queues received bytes in a show-ahead FIFO. The core reads them through an empty / rdreq / q handshake.
- Reports framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 434, system clocks per bit (50 MHz / 115200). Must be ≥ 8.
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 bytes.

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- rxd  in  1  serial line; idle high; asynchronous to clk
- rdreq  in  1  pop the head byte this cycle
- q  out  8  head byte of the FIFO; valid while empty=0
- empty  out  1  FIFO holds no bytes
- full  out  1  FIFO holds 2**DEPTH_LOG2 bytes
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State = IDLE; all counters 0; FIFO pointers 0.
  - Outputs: empty=1, full=0, q=8'h00, frame_err=0, overrun=0.
  - Synchronizer flops preset to 1.
  - Reset asserted mid-frame aborts the frame; no partial byte is pushed.
- Input sync: rxd passes through 2 flops (rx_s). Falling-edge detect uses rx_s and its previous value.
- State IDLE:
  - Go to START on a 1→0 transition of rx_s.
  - A line held low (break) does not retrigger. A new start requires rx_s to return high first.
- State START:
  - Count CLKS_PER_BIT/2 cycles (integer divide), then sample rx_s.
  - 0 → DATA, with bit index 0 and the counter cleared.
  - 1 → false start, back to IDLE; nothing pushed, no error.
- State DATA:
  - Every CLKS_PER_BIT cycles, sample rx_s into shift[bit index], LSB first.
  - After bit 7 is sampled, go to STOP.
- State STOP:
  - After CLKS_PER_BIT cycles, sample rx_s.
  - 1 → issue push of the byte.
  - 0 → frame_err=1 for exactly one cycle; byte discarded.
  - Either case: next state is IDLE.
  - Start-bit falling edge to push ≈ 9.5 bit times.
- FIFO, show-ahead:
  - q always reflects mem[rd_ptr].
  - A push writes at wr_ptr in the push cycle. empty deasserts and q is valid on the following cycle.
  - rdreq with empty=0 advances rd_ptr; the next head appears on q the following cycle.
  - rdreq with empty=1 is ignored; no pointer change.
  - Push with full=1 and rdreq=0: byte dropped, overrun set to 1 and held until reset.
  - Push and rdreq in the same cycle with full=1: the pop frees a slot, the push is accepted, count unchanged, overrun unaffected.
  - Push and rdreq in the same cycle with empty=1: push accepted, pop ignored.
  - Pointers are DEPTH_LOG2+1 bits; wrap-around is natural modulo.
  - full and empty are derived from the pointer MSB and lower-bit compare; both are registered-pointer functions with no combinational path from rdreq.

Test Plan:
1. Single byte, CLKS_PER_BIT=16, DEPTH_LOG2=2: send 8'hA5 (line bits 0,1,0,1,0,0,1,0,1,1 start→stop).
   - empty falls about 152 clks after the start edge; q=8'hA5.
   - Pulse rdreq one cycle → empty=1 next cycle; no frame_err, no overrun.
2. Glitch rejection: drive rxd low for 4 clks, then high.
   - State returns to IDLE; empty stays 1; frame_err never asserts.
   - Then send 8'h3C → q=8'h3C.
3. Framing error: send 8'h55 with the stop bit held low for a full bit time, then release rxd high.
   - frame_err high exactly 1 cycle; empty stays 1.
   - Next byte 8'h12 is received correctly after rxd returns high.
4. Fill and overrun: send 8'h01..8'h05 back-to-back with no rdreq.
   - full=1 after byte 4; byte 5 dropped; overrun=1 and held.
   - Four rdreq pops return 01, 02, 03, 04 in order, then empty=1.
5. Simultaneous push/pop at full: with 4 bytes queued, assert rdreq in the cycle byte 8'h99 is pushed.
   - Count stays 4; overrun stays 0; subsequent drain ends with 8'h99.
6. Reset mid-frame: pulse rst_n low during data bit 3 of 8'hF0.
   - Outputs return to reset values immediately; no byte appears.
   - Next clean byte 8'h0F is received correctly.
